mem_bus_responder: RTL

Synthesizable memory-side responder for the CPU's shared memory bus (address, bidirectional data, `cs_input`/`we`/`oe` strobes). It accepts read and write requests from the fetch/execute sequencer and services them against an internal word array after a configurable number of wait states. It signals completion with a one-cycle `ready` pulse and drives read data onto the shared bus only while the initiator allows it. It replaces the behavioural RAM model when the datapath is moved to hardware.

---
 rtl/mem_bus_pkg.sv | 31 +++
 rtl/mem_bus_responder_if.sv | 39 +++
 rtl/mem_array.sv | 34 +++
 rtl/mem_bus_responder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the memory-bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Wait-state counter width; never zero so the counter always exists.
  function automatic int cnt_w(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

  localparam logic [255:0] c_ERR_DATA = '1;

endpackage

`default_nettype wire

// File: rtl/mem_bus_responder_if.sv
// ============================================================================
// Module      : mem_bus_responder_if
// Description : Request/response strobes of the shared memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_responder_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  cs_input;
  logic                  we;
  logic                  oe;
  logic                  ready;
  logic                  err;

  modport master (
    output addr,
    output cs_input,
    output we,
    output oe,
    input  ready,
    input  err
  );

  modport slave (
    input  addr,
    input  cs_input,
    input  we,
    input  oe,
    output ready,
    output err
  );

endinterface

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// Module      : mem_array
// Description : DEPTH x DATA_WIDTH word store, synchronous write and read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 12
) (
  input  wire logic                  clk,
  input  wire logic                  i_we,
  input  wire logic                  i_re,
  input  wire logic [IDX_W-1:0]      i_addr,
  input  wire logic [DATA_WIDTH-1:0] i_wdata,
  output logic      [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================================
// Module      : mem_bus_responder
// Description : Wait-state memory responder with tri-state read-data drive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  mem_bus_responder_if.slave         bus,
  inout  wire       [DATA_WIDTH-1:0] data
);

  localparam int CNT_W   = cnt_w(WAIT_CYCLES);
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                r_state;
  state_t                w_next;
  op_t                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_oor;
  logic                  r_rd_valid;

  logic                  w_req;
  op_t                   w_acc_op;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic                  w_in_range;
  logic                  w_enter_ack;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic                  w_drive;
  logic [DATA_WIDTH-1:0] w_mem_q;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_req = bus.cs_input & (bus.we | bus.oe);

  // With zero wait states the array is accessed on the sample edge itself,
  // so the live bus feeds the array while idle and the latches afterwards.
  assign w_acc_op    = (r_state == ST_IDLE) ? (bus.we ? OP_WRITE : OP_READ) : r_op;
  assign w_acc_addr  = (r_state == ST_IDLE) ? bus.addr : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? data : r_wdata;
  assign w_in_range  = ({1'b0, w_acc_addr} < c_DEPTH_X);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (r_cnt == CNT_W'(1)) w_next = ST_ACK;
      ST_ACK:  w_next = (r_op == OP_READ && bus.cs_input && bus.oe && !bus.we)
                        ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!bus.cs_input || !bus.oe || bus.we || (bus.addr != r_addr))
                 w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_enter_ack = rst_n && (w_next == ST_ACK);
    w_mem_we    = w_enter_ack && (w_acc_op == OP_WRITE) && w_in_range;
    w_mem_re    = w_enter_ack && (w_acc_op == OP_READ) && w_in_range;
    w_drive     = ((r_state == ST_ACK) || (r_state == ST_HOLD)) &&
                  (r_op == OP_READ) && bus.oe && !bus.we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= OP_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_oor      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_ready <= w_enter_ack;
      r_err   <= w_enter_ack && !w_in_range;
      if (r_state == ST_IDLE && w_req) begin
        r_addr <= bus.addr;
        r_op   <= bus.we ? OP_WRITE : OP_READ;
        r_cnt  <= CNT_W'(WAIT_CYCLES);
        if (bus.we) begin
          r_wdata <= data;
        end
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_enter_ack && (w_acc_op == OP_READ)) begin
        r_oor      <= !w_in_range;
        r_rd_valid <= 1'b1;
      end
    end
  end

  mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (c_IDX_W)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_acc_addr[c_IDX_W-1:0]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_mem_q)
  );

  // Out-of-range reads never touch the array; their data comes from the mux.
  assign w_rdata = !r_rd_valid ? '0 :
                   r_oor       ? c_ERR_DATA[DATA_WIDTH-1:0] : w_mem_q;

  assign data      = w_drive ? w_rdata : 'z;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;

endmodule

`default_nettype wire
